// File: rtl/snoop_bus_controller_pkg.sv
`default_nettype none
// ============================================================================
// Package : coherence_pkg
// Brief   : MSI message/state/op codes and snoop bus controller state encoding
// Rev     : 1.0  initial release
// ============================================================================
package coherence_pkg;

    localparam logic [1:0] c_msg_invalidar    = 2'b00;
    localparam logic [1:0] c_msg_read_miss    = 2'b01;
    localparam logic [1:0] c_msg_write_miss   = 2'b10;
    localparam logic [1:0] c_msg_sem_mensagem = 2'b11;

    typedef enum logic [1:0] {
        invalido      = 2'b00,
        modificado    = 2'b01,
        compartilhado = 2'b10
    } cache_state_e;

    typedef enum logic [1:0] {
        op_none  = 2'b00,
        op_read  = 2'b01,
        op_write = 2'b10
    } cache_op_e;

    localparam int         c_state_w   = 3;
    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_bcast  = 3'd1;
    localparam logic [2:0] c_st_wb     = 3'd2;
    localparam logic [2:0] c_st_mem    = 3'd3;
    localparam logic [2:0] c_st_done   = 3'd4;

    // True when two or more bits are set.
    function automatic logic multi_hot(input logic [7:0] v);
        return |(v & (v - 8'd1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/snoop_bus_controller_if.sv
`default_nettype none
// ============================================================================
// Interface : snoop_bus_controller_if
// Brief     : cache-side request/snoop signals and controller-side bus outputs
// Rev       : 1.0  initial release
// ============================================================================
interface snoop_bus_controller_if #(
    parameter int N_CPU  = 3,
    parameter int ADDR_W = 4
);
    logic [N_CPU-1:0]        req;
    logic [2*N_CPU-1:0]      req_msg;
    logic [ADDR_W*N_CPU-1:0] req_addr;
    logic [N_CPU-1:0]        snoop_wb;
    logic [N_CPU-1:0]        snoop_abort;
    logic [N_CPU-1:0]        grant;
    logic                    bus_valid;
    logic [1:0]              bus_msg;
    logic [ADDR_W-1:0]       bus_addr;
    logic                    mem_wr;
    logic                    mem_rd;
    logic [N_CPU-1:0]        done;
    logic                    busy;
    logic                    protocol_err;

    modport master (
        input  req, req_msg, req_addr, snoop_wb, snoop_abort,
        output grant, bus_valid, bus_msg, bus_addr, mem_wr, mem_rd, done, busy, protocol_err
    );

    modport slave (
        output req, req_msg, req_addr, snoop_wb, snoop_abort,
        input  grant, bus_valid, bus_msg, bus_addr, mem_wr, mem_rd, done, busy, protocol_err
    );
endinterface
`default_nettype wire

// File: rtl/snoop_bus_controller_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : rr_arbiter
// Brief  : combinational round-robin arbiter; nearest eligible after 'last'
// Rev    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int N     = 3,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     eligible,
    input  logic [IDX_W-1:0] last,
    output logic [N-1:0]     winner,
    output logic [IDX_W-1:0] winner_idx,
    output logic             any
);
    localparam logic [N-1:0] c_one = {{(N-1){1'b0}}, 1'b1};

    int w_best;
    int w_dist;

    // Distance 1..N from 'last'; the smallest eligible distance wins.
    always_comb begin
        winner_idx = '0;
        any        = 1'b0;
        w_best     = N + 1;
        w_dist     = 0;
        for (int i = 0; i < N; i++) begin
            w_dist = (i > int'(last)) ? (i - int'(last)) : (i - int'(last) + N);
            if (eligible[i] && (w_dist < w_best)) begin
                w_best     = w_dist;
                winner_idx = IDX_W'(i);
                any        = 1'b1;
            end
        end
        winner = any ? (c_one << winner_idx) : '0;
    end
endmodule
`default_nettype wire

// File: rtl/snoop_bus_controller.sv
`default_nettype none
// ============================================================================
// Module : snoop_bus_controller
// Brief  : round-robin MSI snoop bus sequencer with write-back/read phases
// Rev    : 1.0  initial release
// ============================================================================
module snoop_bus_controller
    import coherence_pkg::*;
#(
    parameter int N_CPU   = 3,
    parameter int ADDR_W  = 4,
    parameter int MEM_LAT = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    snoop_bus_controller_if.master bus
);
    localparam int c_idx_w = $clog2(N_CPU);
    localparam int c_cnt_w = $clog2(MEM_LAT + 1);

    logic [c_state_w-1:0] r_state;
    logic [c_state_w-1:0] w_next;
    logic [N_CPU-1:0]     w_eligible;
    logic [N_CPU-1:0]     w_win;
    logic [c_idx_w-1:0]   w_win_idx;
    logic                 w_any;
    logic [N_CPU-1:0]     r_owner;
    logic [c_idx_w-1:0]   r_owner_idx;
    logic [c_idx_w-1:0]   r_last;
    logic [1:0]           r_msg;
    logic [ADDR_W-1:0]    r_addr;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_err;
    logic [N_CPU-1:0]     w_abort;
    logic [N_CPU-1:0]     w_wb;
    logic                 w_bcast_err;

    genvar g;
    generate
        for (g = 0; g < N_CPU; g++) begin : g_elig
            assign w_eligible[g] = bus.req[g] && (bus.req_msg[2*g +: 2] != c_msg_sem_mensagem);
        end
    endgenerate

    rr_arbiter #(
        .N     (N_CPU),
        .IDX_W (c_idx_w)
    ) u_arb (
        .eligible   (w_eligible),
        .last       (r_last),
        .winner     (w_win),
        .winner_idx (w_win_idx),
        .any        (w_any)
    );

    // The granted cache never snoops its own message.
    assign w_abort     = bus.snoop_abort & ~r_owner;
    assign w_wb        = bus.snoop_wb & ~r_owner;
    assign w_bcast_err = multi_hot(8'(w_abort))
                       || ((r_msg == c_msg_invalidar) && (|w_abort))
                       || (|(w_abort & ~w_wb));

    always_ff @(posedge clock) begin
        if (reset) r_state <= c_st_idle;
        else       r_state <= w_next;
    end

    // Reset leaves r_last at the top index so CPU0 is first in line.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_owner     <= '0;
            r_owner_idx <= '0;
            r_last      <= c_idx_w'(N_CPU - 1);
            r_msg       <= c_msg_sem_mensagem;
            r_addr      <= '0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_any) begin
                        r_owner     <= w_win;
                        r_owner_idx <= w_win_idx;
                        r_msg       <= bus.req_msg[2*w_win_idx +: 2];
                        r_addr      <= bus.req_addr[ADDR_W*w_win_idx +: ADDR_W];
                    end
                end
                c_st_bcast: begin
                    r_cnt <= c_cnt_w'(MEM_LAT);
                    if (w_bcast_err) r_err <= 1'b1;
                end
                c_st_wb, c_st_mem: r_cnt <= r_cnt - 1'b1;
                c_st_done:         r_last <= r_owner_idx;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle:  if (w_any) w_next = c_st_bcast;
            c_st_bcast: begin
                if ((r_msg == c_msg_read_miss) || (r_msg == c_msg_write_miss))
                    w_next = (|w_abort) ? c_st_wb : c_st_mem;
                else
                    w_next = c_st_done;
            end
            c_st_wb, c_st_mem: if (r_cnt == c_cnt_w'(1)) w_next = c_st_done;
            c_st_done:  w_next = c_st_idle;
            default:    w_next = c_st_idle;
        endcase
    end

    always_comb begin
        bus.grant     = '0;
        bus.bus_valid = 1'b0;
        bus.bus_msg   = c_msg_sem_mensagem;
        bus.bus_addr  = '0;
        bus.mem_wr    = 1'b0;
        bus.mem_rd    = 1'b0;
        bus.done      = '0;
        bus.busy      = 1'b0;
        if (r_state != c_st_idle) begin
            bus.grant    = r_owner;
            bus.bus_msg  = r_msg;
            bus.bus_addr = r_addr;
            bus.busy     = 1'b1;
        end
        case (r_state)
            c_st_bcast: bus.bus_valid = 1'b1;
            c_st_wb:    bus.mem_wr    = 1'b1;
            c_st_mem:   bus.mem_rd    = 1'b1;
            c_st_done:  bus.done      = r_owner;
            default: ;
        endcase
    end

    assign bus.protocol_err = r_err;
endmodule
`default_nettype wire

// File: tb/tb_snoop_bus_controller.sv
`default_nettype none
// ============================================================================
// Module : tb_snoop_bus_controller
// Brief  : directed stimulus, transaction-level reference model, literal pins
// Rev    : 1.0  initial release
// ============================================================================
module tb_snoop_bus_controller;
    localparam int N       = 3;
    localparam int AW      = 4;
    localparam int LAT     = 4;

    typedef struct packed {
        logic [2:0] grant;
        logic       bv;
        logic [1:0] msg;
        logic [3:0] addr;
        logic       wr;
        logic       rd;
        logic [2:0] dn;
        logic       busy;
    } out_t;

    logic clock = 1'b0;
    logic reset;
    int   n_total = 0;
    int   n_bad   = 0;

    snoop_bus_controller_if #(.N_CPU(N), .ADDR_W(AW)) bus ();

    snoop_bus_controller #(.N_CPU(N), .ADDR_W(AW), .MEM_LAT(LAT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic out_t idle_out();
        out_t o;
        o     = '0;
        o.msg = 2'b11;
        return o;
    endfunction

    function automatic out_t txn_out(int owner, logic [1:0] msg, logic [3:0] addr,
                                     logic bv, logic wr, logic rd, logic dn);
        out_t o;
        o.grant = 3'(1 << owner);
        o.bv    = bv;
        o.msg   = msg;
        o.addr  = addr;
        o.wr    = wr;
        o.rd    = rd;
        o.dn    = dn ? 3'(1 << owner) : 3'b000;
        o.busy  = 1'b1;
        return o;
    endfunction

    out_t       m_cur;
    out_t       act;
    out_t       sched[$];
    int         m_last;
    int         m_owner;
    logic [1:0] m_msg;
    logic [3:0] m_addr;
    logic       m_err;

    initial begin
        m_cur  = idle_out();
        m_last = N - 1;
        m_err  = 1'b0;
        forever begin
            @(negedge clock);
            act = {bus.grant, bus.bus_valid, bus.bus_msg, bus.bus_addr,
                   bus.mem_wr, bus.mem_rd, bus.done, bus.busy};
            check("model_outputs", 32'(act), 32'(m_cur));
            check("model_protocol_err", 32'(bus.protocol_err), 32'(m_err));
            if (reset) begin
                sched.delete();
                m_cur  = idle_out();
                m_last = N - 1;
                m_err  = 1'b0;
            end else if (m_cur.bv) begin
                int  n_ab;
                bool_blk: begin
                    logic bad_wb;
                    n_ab   = 0;
                    bad_wb = 1'b0;
                    for (int i = 0; i < N; i++) begin
                        if (i != m_owner && bus.snoop_abort[i]) begin
                            n_ab++;
                            if (!bus.snoop_wb[i]) bad_wb = 1'b1;
                        end
                    end
                    if (n_ab > 1 || (m_msg == 2'b00 && n_ab > 0) || bad_wb) m_err = 1'b1;
                end
                if (m_msg != 2'b00)
                    for (int k = 0; k < LAT; k++)
                        sched.push_back(txn_out(m_owner, m_msg, m_addr, 1'b0,
                                                n_ab > 0, n_ab == 0, 1'b0));
                sched.push_back(txn_out(m_owner, m_msg, m_addr, 1'b0, 1'b0, 1'b0, 1'b1));
                m_cur = sched.pop_front();
            end else if (sched.size() > 0) begin
                m_cur = sched.pop_front();
            end else if (m_cur.dn != 3'b000) begin
                m_last = m_owner;
                m_cur  = idle_out();
            end else begin
                bit found;
                found = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (m_last + k) % N;
                    if (!found && bus.req[c] && bus.req_msg[2*c +: 2] != 2'b11) begin
                        found   = 1'b1;
                        m_owner = c;
                        m_msg   = bus.req_msg[2*c +: 2];
                        m_addr  = bus.req_addr[AW*c +: AW];
                    end
                end
                m_cur = found ? txn_out(m_owner, m_msg, m_addr, 1'b1, 1'b0, 1'b0, 1'b0)
                              : idle_out();
            end
        end
    end

    // ---------------- directed stimulus ----------------
    logic [2:0] w_g  [32];
    logic       w_bv [32];
    logic [1:0] w_msg[32];
    logic [3:0] w_adr[32];
    logic       w_rd [32];
    logic       w_wr [32];
    logic [2:0] w_dn [32];
    logic       w_err[32];
    logic [2:0] exp_order[4];

    task automatic set_cpu(input int i, input logic r, input logic [1:0] m, input logic [3:0] a);
        bus.req[i]           = r;
        bus.req_msg[2*i +: 2] = m;
        bus.req_addr[AW*i +: AW] = a;
    endtask

    task automatic snoop(input logic [2:0] wb, input logic [2:0] ab);
        bus.snoop_wb    = wb;
        bus.snoop_abort = ab;
    endtask

    // Records offsets k=0..n relative to the cycle the request was driven in.
    task automatic watch(input int n);
        for (int k = 0; k <= n; k++) begin
            @(negedge clock);
            w_g[k]   = bus.grant;
            w_bv[k]  = bus.bus_valid;
            w_msg[k] = bus.bus_msg;
            w_adr[k] = bus.bus_addr;
            w_rd[k]  = bus.mem_rd;
            w_wr[k]  = bus.mem_wr;
            w_dn[k]  = bus.done;
            w_err[k] = bus.protocol_err;
        end
    endtask

    function automatic int count_rd(int n);
        int s = 0;
        for (int k = 0; k <= n; k++) s += int'(w_rd[k]);
        return s;
    endfunction

    function automatic int count_wr(int n);
        int s = 0;
        for (int k = 0; k <= n; k++) s += int'(w_wr[k]);
        return s;
    endfunction

    function automatic int count_bv(int n);
        int s = 0;
        for (int k = 0; k <= n; k++) s += int'(w_bv[k]);
        return s;
    endfunction

    function automatic logic [2:0] or_grant(int n);
        logic [2:0] s = 3'b000;
        for (int k = 0; k <= n; k++) s |= w_g[k];
        return s;
    endfunction

    initial begin
        exp_order[0] = 3'b001;
        exp_order[1] = 3'b010;
        exp_order[2] = 3'b100;
        exp_order[3] = 3'b001;

        // 1: reset held with all requesting
        reset            = 1'b1;
        bus.req          = 3'b111;
        bus.req_msg      = 6'b010101;
        bus.req_addr     = 12'h321;
        snoop(3'b000, 3'b000);
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("t1_grant", 32'(bus.grant), 32'd0);
        check("t1_bus_msg", 32'(bus.bus_msg), 32'd3);
        check("t1_busy", 32'(bus.busy), 32'd0);
        check("t1_valid_mem", 32'({bus.bus_valid, bus.mem_wr, bus.mem_rd, bus.done}), 32'd0);
        check("t1_err_addr", 32'({bus.protocol_err, bus.bus_addr}), 32'd0);
        @(posedge clock); #1;
        reset   = 1'b0;
        bus.req = 3'b000;

        // 2: CPU1 readMiss addr 5, no aborts
        @(posedge clock); #1;
        set_cpu(1, 1'b1, 2'b01, 4'd5);
        watch(6);
        check("t2_grant", 32'(w_g[1]), 32'b010);
        check("t2_bcast", 32'({w_bv[1], w_msg[1], w_adr[1]}), 32'b1_01_0101);
        check("t2_rd_cycles", 32'(count_rd(6)), 32'd4);
        check("t2_done_early", 32'(w_dn[5]), 32'b000);
        check("t2_done", 32'(w_dn[6]), 32'b010);
        @(posedge clock); #1;
        set_cpu(1, 1'b0, 2'b11, 4'd0);

        // 3: CPU0 writeMiss, CPU2 write-back with abort
        @(posedge clock); #1;
        set_cpu(0, 1'b1, 2'b10, 4'd9);
        snoop(3'b100, 3'b100);
        watch(6);
        check("t3_wr_cycles", 32'(count_wr(6)), 32'd4);
        check("t3_rd_cycles", 32'(count_rd(6)), 32'd0);
        check("t3_done", 32'(w_dn[6]), 32'b001);
        check("t3_no_err", 32'(w_err[6]), 32'd0);
        @(posedge clock); #1;
        set_cpu(0, 1'b0, 2'b11, 4'd0);
        snoop(3'b000, 3'b000);

        // 4: fresh reset, all three readMiss held; CPU0 snoops abort+wb
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0;
        set_cpu(0, 1'b1, 2'b01, 4'd1);
        set_cpu(1, 1'b1, 2'b01, 4'd2);
        set_cpu(2, 1'b1, 2'b01, 4'd3);
        snoop(3'b001, 3'b001);
        watch(27);
        for (int j = 0; j < 4; j++)
            check($sformatf("t4_grant_%0d", j), 32'(w_g[1 + 7*j]), 32'(exp_order[j]));
        check("t4_bcast_count", 32'(count_bv(27)), 32'd4);
        check("t4_rd_cycles", 32'(count_rd(27)), 32'd8);
        check("t4_wr_cycles", 32'(count_wr(27)), 32'd8);
        @(posedge clock); #1;
        bus.req = 3'b000;
        snoop(3'b000, 3'b000);

        // 5: CPU2 invalidar
        @(posedge clock); #1;
        set_cpu(2, 1'b1, 2'b00, 4'd7);
        watch(2);
        check("t5_done_early", 32'(w_dn[1]), 32'b000);
        check("t5_done", 32'(w_dn[2]), 32'b100);
        check("t5_no_mem", 32'(count_rd(2) + count_wr(2)), 32'd0);
        @(posedge clock); #1;
        set_cpu(2, 1'b0, 2'b11, 4'd0);

        // 6: two aborts in BCAST
        @(posedge clock); #1;
        set_cpu(1, 1'b1, 2'b01, 4'd3);
        snoop(3'b101, 3'b101);
        watch(6);
        check("t6_err_before", 32'(w_err[1]), 32'd0);
        check("t6_err_set", 32'(w_err[2]), 32'd1);
        check("t6_err_sticky", 32'(w_err[6]), 32'd1);
        check("t6_wb_phase", 32'(count_wr(6)), 32'd4);
        @(posedge clock); #1;
        set_cpu(1, 1'b0, 2'b11, 4'd0);
        snoop(3'b000, 3'b000);

        // 7: reset mid-MEM; then a req with message 11 is never granted
        @(posedge clock); #1;
        set_cpu(2, 1'b1, 2'b01, 4'd4);
        watch(3);
        @(posedge clock); #1;
        reset = 1'b1;
        set_cpu(2, 1'b0, 2'b11, 4'd0);
        set_cpu(0, 1'b1, 2'b11, 4'd2);
        @(negedge clock);
        check("t7_mid_mem", 32'(bus.mem_rd), 32'd1);
        @(negedge clock);
        check("t7_rst_grant", 32'(bus.grant), 32'd0);
        check("t7_rst_mem_busy", 32'({bus.mem_rd, bus.busy}), 32'd0);
        check("t7_rst_err", 32'(bus.protocol_err), 32'd0);
        check("t7_rst_msg", 32'(bus.bus_msg), 32'd3);
        @(posedge clock); #1;
        reset = 1'b0;
        watch(8);
        check("t7_never_granted", 32'(or_grant(8)), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
